// File: rtl/riscv_pkg.sv
// Shared RV32I encodings, ALU operation codes and sequencer state type
// for the register-bank/ALU control path.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [2:0] FUNCT3_ADDSUB = 3'b000;
  localparam logic [2:0] FUNCT3_AND    = 3'b111;
  localparam logic [2:0] FUNCT3_OR     = 3'b110;
  localparam logic [6:0] FUNCT7_BASE   = 7'h00;
  localparam logic [6:0] FUNCT7_ALT    = 7'h20;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } seq_state_t;

endpackage

// File: rtl/rtype_sequencer_if.sv
// Instruction handshake plus register-bank/ALU datapath signals of the sequencer.
// slave = sequencer side, master = instruction source / datapath side.
interface rtype_sequencer_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_result;
  logic [4:0]  rs_1;
  logic [4:0]  rs_2;
  logic [4:0]  rd_0;
  logic [2:0]  alu_control;
  logic        write_rb;
  logic [31:0] writedata;
  logic        done;
  logic        illegal;

  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, rs_1, rs_2, rd_0, alu_control, write_rb, writedata, done, illegal
  );

  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, rs_1, rs_2, rd_0, alu_control, write_rb, writedata, done, illegal
  );
endinterface

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: ADD/SUB/AND/OR are legal, everything else
// is flagged illegal and reports ALU_ADD so the datapath sees a benign op.
module rtype_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output alu_ctrl_t   alu_control,
  output logic        legal
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       unused_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign unused_s = ^{instr[24:15], instr[11:7]};

  // Opcode/funct3/funct7 lookup
  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b0;
    if (opcode_s == OPCODE_OP) begin
      case (funct3_s)
        FUNCT3_ADDSUB: begin
          if (funct7_s == FUNCT7_BASE) begin
            alu_control = ALU_ADD;
            legal       = 1'b1;
          end else if (funct7_s == FUNCT7_ALT) begin
            alu_control = ALU_SUB;
            legal       = 1'b1;
          end else begin
            alu_control = ALU_ADD;
            legal       = 1'b0;
          end
        end
        FUNCT3_AND: begin
          if (funct7_s == FUNCT7_BASE) begin
            alu_control = ALU_AND;
            legal       = 1'b1;
          end else begin
            alu_control = ALU_ADD;
            legal       = 1'b0;
          end
        end
        FUNCT3_OR: begin
          if (funct7_s == FUNCT7_BASE) begin
            alu_control = ALU_OR;
            legal       = 1'b1;
          end else begin
            alu_control = ALU_ADD;
            legal       = 1'b0;
          end
        end
        default: begin
          alu_control = ALU_ADD;
          legal       = 1'b0;
        end
      endcase
    end else begin
      alu_control = ALU_ADD;
      legal       = 1'b0;
    end
  end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle IDLE->DECODE->EXECUTE->WRITEBACK controller for one R-type
// instruction at a time; addresses and ALU control come straight from IR.
module rtype_sequencer
  import riscv_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  rtype_sequencer_if.slave  bus
);

  seq_state_t  state_r, state_s;
  logic [31:0] ir_r, ir_s;
  logic [31:0] result_r, result_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        illegal_r, illegal_s;
  logic        legal_s;
  alu_ctrl_t   alu_ctrl_s;
  logic        ready_s, done_s, write_s, ill_out_s;

  rtype_decoder u_decoder (
    .instr       (ir_r),
    .alu_control (alu_ctrl_s),
    .legal       (legal_s)
  );

  // Next-state, datapath register updates and strobes
  always_comb begin
    state_s   = state_r;
    ir_s      = ir_r;
    result_s  = result_r;
    cnt_s     = cnt_r;
    illegal_s = illegal_r;
    ready_s   = 1'b0;
    done_s    = 1'b0;
    write_s   = 1'b0;
    ill_out_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s = 1'b1;
        if (bus.instr_valid) begin
          ir_s      = bus.instr;
          illegal_s = 1'b0;
          state_s   = ST_DECODE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (legal_s) begin
          cnt_s     = 4'(SETTLE_CYCLES - 1);
          illegal_s = 1'b0;
          state_s   = ST_EXECUTE;
        end else begin
          illegal_s = 1'b1;
          state_s   = ST_WRITEBACK;
        end
      end
      ST_EXECUTE: begin
        if (cnt_r == 4'd0) begin
          result_s = bus.alu_result;
          state_s  = ST_WRITEBACK;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_WRITEBACK: begin
        done_s    = 1'b1;
        ill_out_s = illegal_r;
        // x0 is hardwired, so a legal write to it still retires without a strobe
        write_s   = ~illegal_r & (ir_r[11:7] != 5'd0);
        state_s   = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ir_r      <= 32'd0;
      result_r  <= 32'd0;
      cnt_r     <= 4'd0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ir_r      <= ir_s;
      result_r  <= result_s;
      cnt_r     <= cnt_s;
      illegal_r <= illegal_s;
    end
  end

  assign bus.instr_ready = ready_s & rst_n;
  assign bus.rs_1        = ir_r[19:15];
  assign bus.rs_2        = ir_r[24:20];
  assign bus.rd_0        = ir_r[11:7];
  assign bus.alu_control = alu_ctrl_s;
  assign bus.write_rb    = write_s;
  assign bus.writedata   = result_r;
  assign bus.done        = done_s;
  assign bus.illegal     = ill_out_s;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Directed bench for rtype_sequencer: table of single instructions on a
// SETTLE_CYCLES=1 instance plus hand sequences on a SETTLE_CYCLES=3 instance.
module tb_rtype_sequencer;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
    logic        ill;
    logic        wr;
    logic [31:0] data;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        sel3_s;
  logic        valid_s;
  logic [31:0] instr_s;
  int          total;
  int          bad;
  vec_t        vecs[8];

  rtype_sequencer_if bus1();
  rtype_sequencer_if bus3();

  rtype_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  rtype_sequencer #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  // Small register-file + ALU model feeding alu_result
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    case (a)
      5'd1:    return 32'd7;
      5'd2:    return 32'd3;
      5'd6:    return 32'd5;
      5'd7:    return 32'd7;
      default: return {27'd0, a};
    endcase
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] c, input logic [4:0] a, input logic [4:0] b);
    case (c)
      3'b010:  return rf_val(a) + rf_val(b);
      3'b110:  return rf_val(a) - rf_val(b);
      3'b000:  return rf_val(a) & rf_val(b);
      3'b001:  return rf_val(a) | rf_val(b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus1.instr_valid = valid_s & ~sel3_s;
  assign bus3.instr_valid = valid_s & sel3_s;
  assign bus1.instr       = instr_s;
  assign bus3.instr       = instr_s;
  assign bus1.alu_result  = alu_model(bus1.alu_control, bus1.rs_1, bus1.rs_2);
  assign bus3.alu_result  = alu_model(bus3.alu_control, bus3.rs_1, bus3.rs_2);

  logic        obs_ready, obs_wr, obs_done, obs_ill;
  logic [4:0]  obs_rs1, obs_rs2, obs_rd;
  logic [2:0]  obs_ctrl;
  logic [31:0] obs_data;
  assign obs_ready = sel3_s ? bus3.instr_ready : bus1.instr_ready;
  assign obs_wr    = sel3_s ? bus3.write_rb    : bus1.write_rb;
  assign obs_done  = sel3_s ? bus3.done        : bus1.done;
  assign obs_ill   = sel3_s ? bus3.illegal     : bus1.illegal;
  assign obs_rs1   = sel3_s ? bus3.rs_1        : bus1.rs_1;
  assign obs_rs2   = sel3_s ? bus3.rs_2        : bus1.rs_2;
  assign obs_rd    = sel3_s ? bus3.rd_0        : bus1.rd_0;
  assign obs_ctrl  = sel3_s ? bus3.alu_control : bus1.alu_control;
  assign obs_data  = sel3_s ? bus3.writedata   : bus1.writedata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One instruction through the selected instance; lat = cycles from accept to WRITEBACK
  task automatic run_one(input vec_t v, input int lat);
    int   k;
    logic stray;
    @(negedge clk);
    check("idle_ready", {31'd0, obs_ready}, 32'd1);
    instr_s = v.instr;
    valid_s = 1'b1;
    @(negedge clk);
    valid_s = 1'b0;
    check("dec_rs1", {27'd0, obs_rs1}, {27'd0, v.rs1});
    check("dec_rs2", {27'd0, obs_rs2}, {27'd0, v.rs2});
    check("dec_ctrl", {29'd0, obs_ctrl}, {29'd0, v.ctrl});
    k = 1;
    stray = 1'b0;
    while (obs_done !== 1'b1 && k < 20) begin
      if (obs_wr !== 1'b0 || obs_ill !== 1'b0 || obs_ctrl !== v.ctrl || obs_rs1 !== v.rs1 || obs_ready !== 1'b0)
        stray = 1'b1;
      @(negedge clk);
      k++;
    end
    check("wb_latency", k, lat);
    check("no_early_strobe", {31'd0, stray}, 32'd0);
    check("wb_write_rb", {31'd0, obs_wr}, {31'd0, v.wr});
    check("wb_illegal", {31'd0, obs_ill}, {31'd0, v.ill});
    check("wb_rd", {27'd0, obs_rd}, {27'd0, v.rd});
    check("wb_ctrl", {29'd0, obs_ctrl}, {29'd0, v.ctrl});
    if (!v.ill) check("wb_data", obs_data, v.data);
    @(negedge clk);
    check("post_done", {30'd0, obs_done, obs_wr}, 32'd0);
  endtask

  initial begin
    int   ndone, nacc, first_wb;
    logic acc, stray;
    total   = 0;
    bad     = 0;
    sel3_s  = 1'b0;
    valid_s = 1'b0;
    instr_s = 32'd0;
    rst_n   = 1'b0;

    vecs[0] = '{32'h002081B3, 5'd1,  5'd2, 5'd3, 3'b010, 1'b0, 1'b1, 32'h0000_000A};
    vecs[1] = '{32'h407302B3, 5'd6,  5'd7, 5'd5, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFFE};
    vecs[2] = '{32'h0020F233, 5'd1,  5'd2, 5'd4, 3'b000, 1'b0, 1'b1, 32'h0000_0003};
    vecs[3] = '{32'h002564B3, 5'd10, 5'd2, 5'd9, 3'b001, 1'b0, 1'b1, 32'h0000_000B};
    vecs[4] = '{32'h00208033, 5'd1,  5'd2, 5'd0, 3'b010, 1'b0, 1'b0, 32'h0000_000A};
    vecs[5] = '{32'h0020C1B3, 5'd1,  5'd2, 5'd3, 3'b010, 1'b1, 1'b0, 32'h0000_0000};
    vecs[6] = '{32'h00208013, 5'd1,  5'd2, 5'd0, 3'b010, 1'b1, 1'b0, 32'h0000_0000};
    vecs[7] = '{32'h4020F233, 5'd1,  5'd2, 5'd4, 3'b010, 1'b1, 1'b0, 32'h0000_0000};

    // Reset held for two edges
    @(negedge clk);
    check("rst_ready", {31'd0, obs_ready}, 32'd0);
    check("rst_strobes", {29'd0, obs_wr, obs_done, obs_ill}, 32'd0);
    check("rst_data", obs_data, 32'd0);
    check("rst_addr", {17'd0, obs_rs1, obs_rs2, obs_rd}, 32'd0);
    check("rst_ctrl", {29'd0, obs_ctrl}, 32'd2);
    @(negedge clk);
    check("rst_ready2", {31'd0, obs_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_ready", {31'd0, obs_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i], vecs[i].ill ? 2 : 3);
    end

    // Back-to-back AND x4 then ADD x0 with instr_valid held
    @(negedge clk);
    instr_s  = 32'h0020F233;
    valid_s  = 1'b1;
    ndone    = 0;
    nacc     = 0;
    first_wb = 0;
    stray    = 1'b0;
    for (int c = 0; c < 14; c++) begin
      acc = valid_s & obs_ready;
      @(negedge clk);
      if (obs_done) begin
        ndone++;
        if (ndone == 1) begin
          first_wb = c;
          check("b2b_and_wr", {31'd0, obs_wr}, 32'd1);
          check("b2b_and_rd", {27'd0, obs_rd}, 32'd4);
          check("b2b_and_ctrl", {29'd0, obs_ctrl}, 32'd0);
          check("b2b_and_data", obs_data, 32'd3);
        end else begin
          check("b2b_x0_wr", {30'd0, obs_wr, obs_ill}, 32'd0);
          check("b2b_x0_rd", {27'd0, obs_rd}, 32'd0);
          check("b2b_gap", c - first_wb, 4);
        end
      end else if (obs_wr || obs_ill) begin
        stray = 1'b1;
      end
      if (acc) begin
        nacc++;
        if (nacc == 1) instr_s = 32'h00208033;
        else valid_s = 1'b0;
      end
    end
    check("b2b_done_count", ndone, 2);
    check("b2b_accept_count", nacc, 2);
    check("b2b_stray", {31'd0, stray}, 32'd0);

    // SETTLE_CYCLES=3 instance
    sel3_s = 1'b1;
    run_one(vecs[1], 5);

    // Reset during EXECUTE abandons the instruction
    @(negedge clk);
    instr_s = 32'h002081B3;
    valid_s = 1'b1;
    @(negedge clk);
    valid_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_strobes", {29'd0, obs_wr, obs_done, obs_ill}, 32'd0);
    check("midrst_ready", {31'd0, obs_ready}, 32'd0);
    check("midrst_data", obs_data, 32'd0);
    check("midrst_ctrl", {24'd0, obs_rs1, obs_ctrl}, 32'd2);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (obs_done || obs_wr || !obs_ready) stray = 1'b1;
    end
    check("midrst_quiet_idle", {31'd0, stray}, 32'd0);
    run_one(vecs[3], 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtype_sequencer.md
Name: rtype_sequencer

Overview:
- Multi-cycle controller that accepts one RV32I R-type instruction per valid/ready handshake and sequences the register-bank/ALU datapath through decode, execute and writeback.
- Drives the datapath's register addresses, ALU control and write strobe, and feeds the captured ALU result back as write data.
- Sits between the instruction source (fetch or test driver) and the datapath.
- Supports ADD, SUB, AND, OR. All other encodings are flagged illegal and retire without a register write.

Parameters:
- SETTLE_CYCLES, 1, cycles spent in EXECUTE before alu_result is captured; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- instr_valid  input  1  instruction offered.
- instr  input  32  RV32I instruction word.
- instr_ready  output  1  sequencer can accept an instruction.
- alu_result  input  32  datapath ALU output.
- rs_1  output  5  register-bank read address A (instr[19:15]).
- rs_2  output  5  register-bank read address B (instr[24:20]).
- rd_0  output  5  register-bank write address (instr[11:7]).
- alu_control  output  3  ALU operation code.
- write_rb  output  1  register-bank write enable.
- writedata  output  32  register-bank write data.
- done  output  1  one-cycle retire pulse.
- illegal  output  1  qualifies done: retired instruction was unsupported.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; instruction register IR and result register cleared to 0.
  - Outputs: instr_ready=0 during the reset cycle, write_rb=0, done=0, illegal=0, writedata=0, rs_1=rs_2=rd_0=0, alu_control=3'b010.
  - Reset mid-operation abandons the instruction with no write and no done.
- Output sourcing:
  - rs_1, rs_2 and rd_0 are sliced from IR; IR changes only on accept.
  - alu_control is decoded from IR.
  - writedata is the result register.
- ALU encoding: ADD=3'b010, SUB=3'b110, AND=3'b000, OR=3'b001.
- Decode (opcode 7'b0110011 required):
  - ADD: funct7 7'h00, funct3 3'b000.
  - SUB: funct7 7'h20, funct3 3'b000.
  - AND: funct7 7'h00, funct3 3'b111.
  - OR: funct7 7'h00, funct3 3'b110.
  - Anything else is illegal; alu_control=3'b010 for illegal encodings.
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, IR<=instr and go to DECODE. instr is ignored when instr_ready=0.
  - DECODE (1 cycle): addresses and alu_control stable.
    - Legal: go to EXECUTE and load the settle counter with SETTLE_CYCLES-1.
    - Illegal: go to WRITEBACK with an illegal flag set.
  - EXECUTE: counter decrements each cycle. When the counter is 0, result<=alu_result and go to WRITEBACK.
  - WRITEBACK (1 cycle): done=1.
    - Legal: write_rb=1 if rd_0!=0. For rd_0==0, write_rb stays 0 but done still pulses.
    - Illegal: write_rb=0, illegal=1.
    - Then go to IDLE.
- Latency: accept at edge N gives WRITEBACK in cycle N+2+SETTLE_CYCLES (4 cycles total at the default). The next accept is possible one cycle after WRITEBACK.
- instr_valid held high continuously gives back-to-back accepts with no lost or duplicated instruction.
- done, illegal and write_rb are never high outside WRITEBACK.
- Addresses and alu_control stay constant from DECODE through WRITEBACK.

Decomposition:
- Package riscv_pkg holds:
  - OPCODE_OP, FUNCT3_ADDSUB/AND/OR, FUNCT7_BASE/ALT.
  - alu_ctrl_t enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR).
  - seq_state_t enum.
- Sub-module rtype_decoder: purely combinational, instr in, alu_control + legal out. It is reused by the later full control unit.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> all outputs at reset values; instr_ready=1 the first cycle after release.
- ADD x3,x1,x2 (32'h002081B3), bench ALU model returns 32'h0000_000A -> rs_1=1, rs_2=2, alu_control=3'b010; 3 cycles after accept write_rb=1, rd_0=3, writedata=32'hA, done=1, illegal=0.
- SUB x5,x6,x7 (32'h407302B3), model returns 32'hFFFF_FFFE, SETTLE_CYCLES=3 -> alu_control=3'b110; WRITEBACK 5 cycles after accept with writedata=32'hFFFF_FFFE.
- AND x4,x1,x2 (32'h0020F233) then ADD x0,x1,x2 (32'h00208033) back-to-back with instr_valid held -> AND writes rd=4 with alu_control=3'b000; ADD x0 gives done=1 with write_rb=0; exactly two done pulses.
- Illegal XOR x3,x1,x2 (32'h0020C1B3) -> done=1, illegal=1 in cycle N+2, write_rb never asserted.
- Reset asserted while in EXECUTE of an ADD -> no write_rb, no done; state IDLE; next instruction completes normally.
